// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Scans DIGITS hex digits over one shared segment bus. Data, masks and the
// leading-zero enable are double-buffered and swapped only at frame end.
// Brightness is applied as PWM inside each digit slot.
module seg_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int DIV_W    = 10,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  load,
  output logic                  load_ack,
  output logic                  frame_tick,
  output logic [DIGITS-1:0]     enable,
  output logic [7:0]            out
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    pcnt;
  logic [IDX_W-1:0]    idx;
  logic                pending;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic                sh_lz;

  logic                slot_end;
  logic                fe;
  logic                capture;
  logic [DIGITS-1:0]   supp;
  logic [DIGITS-1:0]   sel;
  logic [3:0]          nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                cur_supp;
  logic                pwm_on;
  logic [DIGITS-1:0]   enable_d;
  logic [7:0]          out_d;

  function automatic logic [6:0] font(input logic [3:0] n);
    unique case (n)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      4'hF: font = 7'h0E;
    endcase
  endfunction

  assign slot_end = (pcnt == '1);
  assign fe       = slot_end && (idx == LAST);
  assign capture  = fe && (pending || load);

  // Prescaler and digit index: contiguous slots, wrap at end of frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
      if (slot_end)
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // Load handshake and shadow registers; a load on the FE cycle itself is
  // captured directly, so pending never needs to be set in that case.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blank   <= '1;
      sh_lz      <= 1'b0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      load_ack   <= capture;
      frame_tick <= fe;
      if (capture) begin
        pending  <= 1'b0;
        sh_data  <= data;
        sh_dp    <= dp_mask;
        sh_blank <= blank_mask;
        sh_lz    <= lz_en;
      end else if (load) begin
        pending  <= 1'b1;
      end
    end
  end

  // Leading-zero mask: walk from the top digit down; digit 0 always shows.
  always_comb begin
    logic seen;
    supp = '0;
    seen = 1'b0;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      seen = seen | (sh_data[4*(DIGITS-1-k) +: 4] != 4'h0);
      supp[DIGITS-1-k] = sh_lz & ~seen;
    end
  end

  // Select the scanned digit's attributes and form the next outputs.
  always_comb begin
    sel       = '0;
    nib       = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel[i]    = 1'b1;
        nib       = sh_data[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_blank = sh_blank[i];
        cur_supp  = supp[i];
      end
    end
    pwm_on   = (pcnt[DIV_W-1 -: BRIGHT_W] <= brightness);
    enable_d = '1;
    out_d    = 8'hFF;
    if (cur_blank || !pwm_on) begin
      enable_d = '1;
      out_d    = 8'hFF;
    end else if (cur_supp) begin
      if (cur_dp) begin
        enable_d = ~sel;
        out_d    = 8'h7F;
      end
    end else begin
      enable_d = ~sel;
      out_d    = {~cur_dp, font(nib)};
    end
  end

  // Registered anode and segment drive (one cycle behind the scan state).
  always_ff @(posedge clk) begin
    if (rst) begin
      enable <= '1;
      out    <= 8'hFF;
    end else begin
      enable <= enable_d;
      out    <= out_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV_W=2, BRIGHT_W=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_en = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        load = 1'b0;
  logic        load_ack;
  logic        frame_tick;
  logic [3:0]  enable;
  logic [7:0]  out;

  int total = 0;
  int bad   = 0;
  int acks  = 0;
  int n     = 0;   // cycles since reset; n % 16 is the scan state index

  seg_scan_ctrl #(.DIGITS(4), .DIV_W(2), .BRIGHT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .brightness (brightness),
    .load       (load),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .enable     (enable),
    .out        (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) n <= rst ? 0 : n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (load_ack) acks++;
  endtask

  task automatic to_slot(input int m);
    while (n % 16 != m) step();
  endtask

  // Check one whole frame; bytes holds the lit segment value per digit
  // {d3,d2,d1,d0}, FF meaning the digit is dark.
  task automatic frame_chk(input string tag, input logic [31:0] bytes, input logic [1:0] b);
    logic [7:0]  eb;
    logic [3:0]  en;
    logic [11:0] exp;
    to_slot(0);
    brightness = b;
    for (int k = 0; k < 16; k++) begin
      step();
      eb = bytes[8*(k/4) +: 8];
      en = 4'hF;
      if (eb != 8'hFF && (k % 4) <= int'(b)) begin
        en[k/4] = 1'b0;
        exp = {en, eb};
      end else begin
        exp = 12'hFFF;
      end
      chk(tag, {enable, out}, exp);
      chk({tag, "_ft"}, frame_tick, (k == 15));
    end
  endtask

  task automatic load_cap(input string tag);
    int a0;
    a0 = acks;
    load = 1'b1;
    step();
    load = 1'b0;
    to_slot(0);
    chk({tag, "_ack"}, load_ack, 1'b1);
    chk({tag, "_nack"}, acks - a0, 1);
  endtask

  initial begin
    int a0;
    // 1. reset
    step();
    chk("rst_ack", load_ack, 1'b0);
    chk("rst_ft", frame_tick, 1'b0);
    step();
    chk("rst_ack2", load_ack, 1'b0);
    chk("rst_ft2", frame_tick, 1'b0);
    chk("rst_out", {enable, out}, 12'hFFF);
    rst = 1'b0;
    a0 = acks;
    repeat (3) frame_chk("dark", 32'hFFFF_FFFF, 2'd3);
    chk("dark_nack", acks - a0, 0);

    // 2. basic update
    data = 16'h12AF; dp_mask = '0; blank_mask = '0; lz_en = 1'b0;
    load_cap("basic");
    frame_chk("basic", 32'hF9A4_888E, 2'd3);

    // 4. brightness on the same shadow contents
    frame_chk("bri0", 32'hF9A4_888E, 2'd0);
    frame_chk("bri1", 32'hF9A4_888E, 2'd1);
    brightness = 2'd3;

    // 3. leading-zero suppression, dp, blank priority
    data = 16'h0005; lz_en = 1'b1;
    load_cap("lz");
    frame_chk("lz", 32'hFFFF_FF92, 2'd3);
    dp_mask = 4'b0100;
    load_cap("lzdp");
    frame_chk("lzdp", 32'hFF7F_FF92, 2'd3);
    blank_mask = 4'b0100;
    load_cap("blk");
    frame_chk("blk", 32'hFFFF_FF92, 2'd3);
    data = 16'h0000; dp_mask = '0; blank_mask = '0;
    load_cap("zero");
    frame_chk("zero", 32'hFFFF_FFC0, 2'd3);

    // 5a. two loads in one frame merge into one ack
    data = 16'h12AF; lz_en = 1'b0;
    a0 = acks;
    load = 1'b1; step(); load = 1'b0;
    repeat (4) step();
    load = 1'b1; step(); load = 1'b0;
    to_slot(0);
    chk("dbl_ack", load_ack, 1'b1);
    frame_chk("dbl", 32'hF9A4_888E, 2'd3);
    chk("dbl_nack", acks - a0, 1);

    // 5b. data changed after load: FE-cycle value is captured
    data = 16'h1111;
    load = 1'b1; step(); load = 1'b0;
    to_slot(8);
    data = 16'h2345;
    to_slot(0);
    chk("late_ack", load_ack, 1'b1);
    frame_chk("late", 32'hA4B0_9992, 2'd3);

    // 5c. load on the FE cycle itself
    data = 16'hC0DE; lz_en = 1'b1;
    a0 = acks;
    to_slot(15);
    load = 1'b1; step(); load = 1'b0;
    chk("fe_ack", load_ack, 1'b1);
    step();
    chk("fe_ack_pulse", load_ack, 1'b0);
    frame_chk("fe", 32'hC6C0_A186, 2'd3);
    chk("fe_nack", acks - a0, 1);

    // 6. reset with a load pending
    data = 16'h8888; lz_en = 1'b0;
    load = 1'b1; step(); load = 1'b0;
    to_slot(6);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_out", {enable, out}, 12'hFFF);
    chk("mrst_ack", load_ack, 1'b0);
    chk("mrst_ft", frame_tick, 1'b0);
    a0 = acks;
    repeat (2) frame_chk("mrst", 32'hFFFF_FFFF, 2'd3);
    chk("mrst_nack", acks - a0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment display controller. It is the successor to the fixed 8-digit display driver in the MIPS CPU board top level. It time-multiplexes DIGITS hex digits onto one shared segment bus, and adds:
- tear-free frame-synchronous data update with a load/acknowledge handshake
- per-digit decimal-point and blank masks
- leading-zero suppression
- PWM brightness control

It sits between the CPU debug/display register and the board's anode/cathode pins.

## Interface
- DIGITS, 8: number of digits scanned (1..16).
- DIV_W, 10: prescaler width; each digit slot lasts DIV = 2^DIV_W clk cycles.
- BRIGHT_W, 4: brightness field width; must satisfy BRIGHT_W <= DIV_W.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost.
- dp_mask  in  DIGITS  1 = light the decimal point of digit i.
- blank_mask  in  DIGITS  1 = digit i fully dark.
- lz_en  in  1  leading-zero suppression enable.
- brightness  in  BRIGHT_W  PWM level; sampled live, not shadowed.
- load  in  1  update request; a one-cycle pulse or held level is accepted.
- load_ack  out  1  one-cycle pulse: shadow registers updated.
- frame_tick  out  1  one-cycle pulse per completed frame.
- enable  out  DIGITS  anode selects, active-low.
- out  out  8  segments, active-low; out[6:0] = g..a, out[7] = dp.

## Operation
- Prescaler `pcnt` counts 0..DIV-1 and wraps. On the wrap, digit index `idx` advances 0..DIGITS-1 and wraps to 0.
- Frame end (FE) is the cycle where pcnt = DIV-1 and idx = DIGITS-1.
- `pending` is set by load. Capture occurs on the first FE cycle with (pending | load).
  - At capture, data, dp_mask, blank_mask and lz_en are sampled from that same cycle into shadow registers, and pending is cleared.
  - Repeated loads before capture merge into one capture and one ack.
- Leading-zero mask is computed from the shadow values. Scanning from digit DIGITS-1 downward, every zero nibble before the first nonzero nibble is suppressed. Digit 0 is never suppressed. Suppression is inactive when shadow lz_en = 0.
- Per-digit output for idx = i, evaluated in priority order:
  - Shadow blank[i], or PWM off: enable[i] = 1, out = 8'hFF.
  - Suppressed with dp[i] = 0: anode off, out = 8'hFF.
  - Suppressed with dp[i] = 1: anode on, out = 8'h7F.
  - Otherwise: anode on, out[6:0] = font(nibble), out[7] = ~dp[i].
- PWM: the digit is on when pcnt[DIV_W-1 -: BRIGHT_W] <= brightness. All-ones gives 100% duty; 0 gives 1/2^BRIGHT_W duty.
- Font (out[6:0], hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- All non-idx enable bits are 1. At most one anode is low at any time.

## Timing
- Reset values (the cycle after rst sampled high): pcnt = 0, idx = 0, pending = 0, shadow data = 0, dp = 0, blank = all ones, lz_en = 0, enable = all ones, out = 8'hFF, load_ack = 0, frame_tick = 0.
- After reset the display stays dark until the first capture.
- Reset mid-frame discards any pending load; no ack is issued.
- enable and out are registered: they reflect the idx/pcnt state of the previous cycle (one-cycle latency).
- load_ack and frame_tick are registered: each is high for exactly the one cycle after the relevant FE cycle.
- Frame period = DIGITS * DIV cycles. Digit slots are contiguous, with no dead cycles between them.
- A load asserted on the FE cycle itself is captured in that cycle.
- New shadow values first affect the outputs in digit 0 of the next frame.

## Test plan
Bench parameters: DIGITS=4, DIV_W=2, BRIGHT_W=2.

1. Reset: rst high for 2 cycles, then run 3 frames with no load → enable = 4'hF, out = 8'hFF throughout; load_ack and frame_tick stay 0 during reset.
2. Basic update: load pulse with data = 16'h12AF, masks = 0, lz_en = 0, brightness = 3 → load_ack pulses once after the next FE. The next frame shows, 4 cycles each:
   - enable 1110 / out 8E
   - enable 1101 / out 88
   - enable 1011 / out A4
   - enable 0111 / out F9
3. Leading-zero suppression and dp:
   - data = 16'h0005, lz_en = 1 → digits 3..1 have anode off; digit 0 shows 8'h92.
   - Repeat with dp_mask = 4'b0100 → digit 2 shows anode on, out = 8'h7F.
   - data = 0 → digit 0 shows 8'hC0.
4. Brightness: brightness = 0 → each anode is low for only 1 of every 4 cycles of its slot. brightness = 1 → low for 2 of every 4.
5. Handshake edges:
   - Two load pulses in one frame → exactly one ack.
   - data changed between load and FE → the FE-cycle value is displayed.
   - load asserted on the FE cycle → captured in that cycle, ack in the next cycle.
6. Reset mid-operation: with load pending, assert rst mid-frame → no ack; all outputs return to reset values and the display stays dark.
